// File: rtl/input_precision_selection.sv
`default_nettype none
// ============================================================================
// Module   : input_precision_selection
// Brief    : Packs W/2-bit operand words into a widened X/Y pair for the BKM core.
// Revision : 1.0 - initial release
// ============================================================================
module input_precision_selection #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           enable,
    input  logic [1:0]     format,
    input  logic [W/2-1:0] in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [W-1:0]   X_out,
    output logic [W-1:0]   Y_out,
    output logic [1:0]     out_format,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err
);

    localparam int c_HALF = W / 2;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_HOLD    = 2'd3;

    localparam logic [1:0] c_REAL_32  = 2'b00;
    localparam logic [1:0] c_CMPLX_32 = 2'b10;
    localparam logic [1:0] c_CMPLX_64 = 2'b11;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [1:0]   r_idx;
    logic [1:0]   r_fmt;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic         r_err;
    logic         w_err_nxt;
    logic         w_accept;
    logic [W-1:0] w_sext;

    // Index of the final word of a packet (packet length minus one).
    function automatic logic [1:0] last_idx(input logic [1:0] f);
        case (f)
            c_REAL_32:  last_idx = 2'd0;
            c_CMPLX_64: last_idx = 2'd3;
            default:    last_idx = 2'd1;
        endcase
    endfunction

    assign w_accept = in_valid & in_ready;
    assign w_sext   = {{c_HALF{in_data[c_HALF-1]}}, in_data};

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= c_IDLE;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    // A last marker that arrives early, or a missing one, drops the pair.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (last_idx(format) == 2'd0) begin
                        if (in_last) begin
                            w_state_nxt = c_HOLD;
                        end else begin
                            w_state_nxt = c_DRAIN;
                            w_err_nxt   = 1'b1;
                        end
                    end else if (in_last) begin
                        w_state_nxt = c_IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = c_COLLECT;
                    end
                end
            end
            c_COLLECT: begin
                if (w_accept) begin
                    if (r_idx == last_idx(r_fmt)) begin
                        if (in_last) begin
                            w_state_nxt = c_HOLD;
                        end else begin
                            w_state_nxt = c_DRAIN;
                            w_err_nxt   = 1'b1;
                        end
                    end else if (in_last) begin
                        w_state_nxt = c_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            c_DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                if (out_ready && enable) begin
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        out_valid = (r_state == c_HOLD);
        in_ready  = enable & ~srst & (r_state != c_HOLD);
    end

    // Operand registers are written in place; out_valid qualifies them.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_fmt <= c_REAL_32;
            r_idx <= '0;
            r_err <= 1'b0;
        end else if (enable) begin
            r_err <= w_err_nxt;
            if (w_accept && (r_state == c_IDLE)) begin
                r_fmt <= format;
                r_idx <= 2'd1;
                r_y   <= '0;
                if (format[0]) begin
                    r_x <= {{c_HALF{1'b0}}, in_data};
                end else begin
                    r_x <= w_sext;
                end
            end else if (w_accept && (r_state == c_COLLECT)) begin
                r_idx <= r_idx + 2'd1;
                if (r_fmt == c_CMPLX_32) begin
                    r_y <= w_sext;
                end else if (r_idx == 2'd1) begin
                    r_x[W-1:c_HALF] <= in_data;
                end else if (r_idx == 2'd2) begin
                    r_y[c_HALF-1:0] <= in_data;
                end else begin
                    r_y[W-1:c_HALF] <= in_data;
                end
            end
            if (w_state_nxt == c_IDLE) begin
                r_idx <= '0;
            end
        end
    end

    assign X_out      = r_x;
    assign Y_out      = r_y;
    assign out_format = r_fmt;
    assign err        = r_err & enable;

endmodule
`default_nettype wire

// File: tb/tb_input_precision_selection.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_precision_selection
// Brief    : Randomized scoreboard bench for input_precision_selection.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_input_precision_selection;

    localparam int W = 64;

    logic          clk;
    logic          srst;
    logic          enable;
    logic [1:0]    format;
    logic [W/2-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [W-1:0]  X_out;
    logic [W-1:0]  Y_out;
    logic [1:0]    out_format;
    logic          out_valid;
    logic          out_ready;
    logic          err;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic [1:0]  f;
    } pair_t;

    pair_t expq[$];
    int    err_exp;
    int    nvec;
    int    nmis;
    logic  rnd;

    input_precision_selection #(.W(W)) dut (
        .clk(clk), .srst(srst), .enable(enable), .format(format),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .X_out(X_out), .Y_out(Y_out),
        .out_format(out_format), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int plen(input logic [1:0] f);
        case (f)
            2'b00:   return 1;
            2'b11:   return 4;
            default: return 2;
        endcase
    endfunction

    function automatic pair_t model(input logic [1:0] f, input logic [31:0] w [5]);
        pair_t p;
        p.f = f;
        p.x = 64'd0;
        p.y = 64'd0;
        case (f)
            2'b00: p.x = 64'($signed(w[0]));
            2'b01: p.x = {w[1], w[0]};
            2'b10: begin
                p.x = 64'($signed(w[0]));
                p.y = 64'($signed(w[1]));
            end
            default: begin
                p.x = {w[1], w[0]};
                p.y = {w[3], w[2]};
            end
        endcase
        return p;
    endfunction

    // Background handshake/enable jitter during the random phase.
    always @(posedge clk) begin
        #2;
        if (rnd) begin
            out_ready = ($urandom_range(0, 2) != 0);
            enable    = ($urandom_range(0, 9) != 0);
        end
    end

    // Scoreboard monitor: pops on every output transfer and every err pulse.
    always @(negedge clk) begin
        pair_t e;
        if (!srst && enable && out_valid && out_ready) begin
            check("pair_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("X_out", X_out, e.x);
                check("Y_out", Y_out, e.y);
                check("out_format", 64'(out_format), 64'(e.f));
            end
        end
        if (err) begin
            check("err_expected", 64'(err_exp > 0), 64'd1);
            if (err_exp > 0) err_exp--;
        end
    end

    task automatic send_word(input logic [1:0] f, input logic [31:0] d, input logic l);
        int n;
        n = 0;
        format   = f;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                nvec++;
                nmis++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends L words; the packet is well formed only when L matches the format.
    task automatic send_pkt(input logic [1:0] f, input int L, input logic [31:0] w [5]);
        if (L == plen(f)) expq.push_back(model(f, w));
        else err_exp++;
        for (int i = 0; i < L; i++) begin
            send_word((i == 0) ? f : 2'($urandom_range(0, 3)), w[i], (i == L - 1));
        end
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((expq.size() != 0 || err_exp != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("queue_drained", 64'(expq.size()), 64'd0);
        check("err_drained", 64'(err_exp), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wv [5];
        pair_t       e;
        int          f, L;
        nvec = 0; nmis = 0; err_exp = 0; rnd = 1'b0;
        srst = 1'b1; enable = 1'b1; format = 2'b00; in_data = '0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_X", X_out, 64'd0);
        check("rst_Y", Y_out, 64'd0);
        check("rst_fmt", 64'(out_format), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        srst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // REAL_32 sign extension, held then released
        wv = '{32'h8000_0001, 0, 0, 0, 0};
        send_pkt(2'b00, 1, wv);
        check("r32_valid", 64'(out_valid), 64'd1);
        check("r32_X", X_out, 64'hFFFF_FFFF_8000_0001);
        check("r32_Y", Y_out, 64'd0);
        check("r32_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("r32_valid_fall", 64'(out_valid), 64'd0);

        // CMPLX_64 word order
        wv = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0};
        send_pkt(2'b11, 4, wv);
        check("c64_X", X_out, 64'h2222_2222_1111_1111);
        check("c64_Y", Y_out, 64'h4444_4444_3333_3333);
        check("c64_fmt", 64'(out_format), 64'd3);
        @(posedge clk);
        #1;

        // CMPLX_32 held for five cycles
        out_ready = 1'b0;
        wv = '{32'h7654_3210, 32'h9ABC_DEF0, 0, 0, 0};
        e = model(2'b10, wv);
        send_pkt(2'b10, 2, wv);
        repeat (5) begin
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_X", X_out, e.x);
            check("hold_Y", Y_out, e.y);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_ready", 64'(in_ready), 64'd1);

        // REAL_64 with last on the first word
        wv = '{32'hDEAD_BEEF, 0, 0, 0, 0};
        send_pkt(2'b01, 1, wv);
        check("short_err", 64'(err), 64'd1);
        check("short_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("short_err_fall", 64'(err), 64'd0);

        // CMPLX_32 overrun, drained, then a clean REAL_32
        wv = '{32'h1, 32'h2, 32'h3, 32'h4, 0};
        send_pkt(2'b10, 4, wv);
        check("drain_valid", 64'(out_valid), 64'd0);
        wv = '{32'h0000_1234, 0, 0, 0, 0};
        send_pkt(2'b00, 1, wv);
        check("after_drain_X", X_out, 64'h0000_0000_0000_1234);
        wait_drained();

        // Reset in the middle of a CMPLX_64 packet
        send_word(2'b11, 32'hAAAA_AAAA, 1'b0);
        send_word(2'b11, 32'hBBBB_BBBB, 1'b0);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        check("mid_rst_X", X_out, 64'd0);
        check("mid_rst_Y", Y_out, 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        wv = '{32'hFFFF_FFFE, 0, 0, 0, 0};
        send_pkt(2'b00, 1, wv);
        check("post_rst_X", X_out, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_drained();

        // enable low for three cycles mid-packet
        wv = '{32'h0BAD_F00D, 32'h8765_4321, 0, 0, 0};
        e = model(2'b10, wv);
        expq.push_back(e);
        send_word(2'b10, wv[0], 1'b0);
        format = 2'b10; in_data = wv[1]; in_last = 1'b1; in_valid = 1'b1;
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("en_in_ready", 64'(in_ready), 64'd0);
            check("en_X_frozen", X_out, e.x);
            check("en_Y_frozen", Y_out, 64'd0);
            @(posedge clk);
            #1;
        end
        enable = 1'b1;
        @(negedge clk);
        check("en_back_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("en_valid", 64'(out_valid), 64'd1);
        check("en_Y", Y_out, e.y);
        wait_drained();

        // Randomized packets, including malformed lengths
        rnd = 1'b1;
        for (int p = 0; p < 80; p++) begin
            foreach (wv[i]) wv[i] = $urandom;
            f = $urandom_range(0, 3);
            L = ($urandom_range(0, 4) != 0) ? plen(2'(f)) : $urandom_range(1, 5);
            send_pkt(2'(f), L, wv);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        rnd = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        wait_drained();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
